keypad_scanner: RTL
===================

# keypad_scanner

Matrix keypad front end for the calculator. It drives the 4x4 keypad columns and samples the rows on workClk, then debounces the press. The accepted key is decoded into the digit, operator and submit signals that the control unit consumes. Outputs are registered levels that stay high while the key is held, so the control unit's state machine can wait on both press and release.

## Interface
- SCAN_CYCLES, 4: workClk cycles per sample period (column dwell); must be ≥2.
- DEBOUNCE, 3: consecutive agreeing samples required to accept a press or a release; must be ≥1.

- workClk  input  1  clock
- reset  input  1  asynchronous, active-low; clock workClk
- row  input  4  keypad rows, active-low (pulled up externally); treated as synchronous to workClk
- col  output  4  column drive, active-low one-hot
- num  output  4  last accepted digit, 0–9
- numPressed  output  1  high while an accepted digit key is held
- opt  output  3  last accepted operator, 1–5
- optPressed  output  1  high while an accepted operator key is held
- submit  output  1  high while the accepted submit key is held

## Operation
- Key code is {row_idx[1:0], col_idx[1:0]}, where row_idx is the row bit position and col_idx is the driven column.
  - Codes 0–9 map to a digit: num = code.
  - Codes 10–14 map to an operator: opt = code − 9.
  - Code 15 maps to submit.
- Sample tick: a divider counts 0..SCAN_CYCLES−1 and wraps. The tick is the edge on which the divider equals SCAN_CYCLES−1. All FSM decisions happen only on ticks.
- SCAN state:
  - At a tick with row == 4'hF, advance the column: 1110→1101→1011→0111→1110 (wrap).
  - At a tick with any row low, capture the lowest-index low row plus the current column, set match count = 1, freeze the column and go to CONFIRM.
- CONFIRM state:
  - At a tick where the captured row bit is still low, increment the count.
  - When the count reaches DEBOUNCE, go to HELD. On the same edge, load num or opt (per the code) and set the matching pressed flag.
  - At a tick where the captured row bit is high, go to SCAN and advance the column. No output changes.
  - With DEBOUNCE = 1, the first SCAN capture goes directly to HELD.
- HELD state:
  - Only the captured row bit is watched. Other keys pressed meanwhile are ignored; the column stays frozen.
  - Each tick with the bit high increments the release count. Each tick with the bit low clears it.
  - When the release count reaches DEBOUNCE: clear all pressed flags, go to SCAN, advance the column.
- num and opt hold their last accepted values indefinitely. A digit press never changes opt, and an operator press never changes num.
- At most one of numPressed / optPressed / submit is high at any time.

## Timing
- Reset (asynchronous, active-low) values:
  - col = 4'b1110, num = 0, opt = 0; numPressed, optPressed, submit = 0.
  - State SCAN, divider 0, counts 0.
- Reset asserted mid-press: all of the above apply immediately. After release, the held key is re-scanned from column 0 and must re-qualify through CONFIRM.
- All outputs are registered and change only on workClk rising edges.
- Press latency from the capturing tick to the flag rising: (DEBOUNCE−1)·SCAN_CYCLES cycles.
- Worst-case latency from a stable press to the flag: (4 + DEBOUNCE−1)·SCAN_CYCLES cycles. With the defaults this is 24 cycles.
- Release latency from the first high tick: (DEBOUNCE−1)·SCAN_CYCLES cycles, plus up to SCAN_CYCLES−1 cycles of tick alignment.
- Ticks occur on edges SCAN_CYCLES, 2·SCAN_CYCLES, … after reset release.

## Test plan
- Defaults, key 7 (row 1, col 3) held from reset release:
  - col steps 1110, 1101, 1011, 0111 at edges 4, 8, 12.
  - Capture at edge 16; numPressed rises after edge 24 with num = 7.
  - Release after edge 24: numPressed falls after edge 36 and col = 1110.
- Bounce: key 14 (row 3, col 2) low for one tick, high at the next tick, then stable:
  - The first capture aborts to SCAN with no output change.
  - The later stable press gives optPressed = 1 and opt = 5; num is unchanged from its previous value.
- Submit (row 3, col 3) held, with key 0 also pressed during HELD:
  - submit stays high and numPressed stays low throughout.
  - After the submit key releases, key 0 is scanned and accepted: num = 0, numPressed = 1.
- Two rows low in the same column (rows 0 and 2, col 1): code 1 is accepted, num = 1.
- Reset driven low while optPressed = 1:
  - All flags and num/opt clear immediately and col = 1110.
  - After reset deasserts with the key still held, optPressed returns after full re-qualification, not earlier.
- DEBOUNCE = 1, SCAN_CYCLES = 2, key 3 (row 0, col 3):
  - numPressed rises at the tick that samples col 3, which is edge 8 after reset release.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns, samples rows once per sample period,
// debounces press and release of one key, and decodes it into digit/operator/submit levels.
module keypad_scanner #(
    parameter int SCAN_CYCLES = 4,
    parameter int DEBOUNCE    = 3
) (
    input  logic       workClk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] num,
    output logic       numPressed,
    output logic [2:0] opt,
    output logic       optPressed,
    output logic       submit
);

    localparam int DIV_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] count;      // match count in CONFIRM, release count in HELD
    logic [1:0]       cap_row;
    logic [1:0]       cap_col;

    logic       tick;
    logic       any_low;
    logic       cap_low;
    logic [1:0] low_row;
    logic [1:0] col_idx;
    logic       accept;
    logic [3:0] accept_code;

    assign tick    = (div == DIV_LAST);
    assign any_low = (row != 4'hF);
    assign cap_low = ~row[cap_row];

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        low_row = 2'd0;
        if (!row[0])      low_row = 2'd0;
        else if (!row[1]) low_row = 2'd1;
        else if (!row[2]) low_row = 2'd2;
        else if (!row[3]) low_row = 2'd3;
    end

    always_comb begin
        col_idx = 2'd0;
        case (col)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // A key is accepted either straight from SCAN (single-sample debounce) or on the last CONFIRM match.
    always_comb begin
        accept      = 1'b0;
        accept_code = {cap_row, cap_col};
        if (tick) begin
            if (state == SCAN && any_low && DEBOUNCE == 1) begin
                accept      = 1'b1;
                accept_code = {low_row, col_idx};
            end else if (state == CONFIRM && cap_low && count == CNT_LAST) begin
                accept = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously on reset low.
    always_ff @(posedge workClk or negedge reset) begin
        if (!reset) begin
            state      <= SCAN;
            div        <= '0;
            count      <= '0;
            cap_row    <= 2'd0;
            cap_col    <= 2'd0;
            col        <= 4'b1110;
            num        <= 4'd0;
            opt        <= 3'd0;
            numPressed <= 1'b0;
            optPressed <= 1'b0;
            submit     <= 1'b0;
        end else begin
            div <= tick ? '0 : div + 1'b1;

            if (tick) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            cap_row <= low_row;
                            cap_col <= col_idx;
                            if (DEBOUNCE == 1) begin
                                state <= HELD;
                                count <= '0;
                            end else begin
                                state <= CONFIRM;
                                count <= CNT_W'(1);
                            end
                        end else begin
                            col <= {col[2:0], col[3]};
                        end
                    end

                    CONFIRM: begin
                        if (cap_low) begin
                            if (count == CNT_LAST) begin
                                state <= HELD;
                                count <= '0;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end else begin
                            state <= SCAN;
                            count <= '0;
                            col   <= {col[2:0], col[3]};
                        end
                    end

                    HELD: begin
                        if (cap_low) begin
                            count <= '0;
                        end else if (count == CNT_LAST) begin
                            state      <= SCAN;
                            count      <= '0;
                            col        <= {col[2:0], col[3]};
                            numPressed <= 1'b0;
                            optPressed <= 1'b0;
                            submit     <= 1'b0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end

                    default: begin
                        state <= SCAN;
                        count <= '0;
                    end
                endcase
            end

            if (accept) begin
                if (accept_code < 4'd10) begin
                    num        <= accept_code;
                    numPressed <= 1'b1;
                end else if (accept_code < 4'd15) begin
                    opt        <= 3'(accept_code - 4'd9);
                    optPressed <= 1'b1;
                end else begin
                    submit <= 1'b1;
                end
            end
        end
    end

endmodule
